// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program-counter controller.
// Controller states and the two instruction step sizes.
package pc_pkg;

   typedef enum logic [1:0] {
      PC_BOOT = 2'd0,
      PC_RUN  = 2'd1,
      PC_HALT = 2'd2
   } pc_state_t;

   localparam int PC_STEP_32 = 4;
   localparam int PC_STEP_16 = 2;

endpackage

// File: rtl/pc_next_sel.sv
// Next-pc select: trap > redirect > sequential step > hold, with target alignment.
// Purely combinational; misaligned flags a redirect target whose dropped low bits were set.
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter bit C_EXT = 1'b0
) (
   input  logic [XLEN-1:0] pc,
   input  logic            accept,
   input  logic            instr_len,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   output logic [XLEN-1:0] pc_next,
   output logic            misaligned,
   output logic            squash
);

   localparam logic [XLEN-1:0] LOW2       = XLEN'(3);
   localparam logic [XLEN-1:0] LOW1       = XLEN'(1);
   localparam logic [XLEN-1:0] REDIR_LOW  = C_EXT ? LOW1 : LOW2;

   logic [XLEN-1:0] step;

   always_comb begin
      step       = (C_EXT && instr_len) ? XLEN'(PC_STEP_16) : XLEN'(PC_STEP_32);
      pc_next    = pc;
      misaligned = 1'b0;
      if (trap_valid) begin
         pc_next = trap_pc & ~LOW2;
      end else if (redirect_valid) begin
         pc_next    = redirect_pc & ~REDIR_LOW;
         misaligned = |(redirect_pc & REDIR_LOW);
      end else if (accept) begin
         pc_next = pc + step;
      end
   end

   assign squash = trap_valid | redirect_valid;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC controller: offers pc over valid/ready; pc updates one cycle after trap/redirect/accept.
// Back-pressure (fetch_ready low) holds pc and fetch_valid; a redirect may still replace pc.
module pc_gen
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter bit              C_EXT        = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_ready,
   input  logic            instr_len,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            halt_req,
   input  logic            resume,
   output logic            fetch_valid,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_prev,
   output logic            pc_prev_valid,
   output logic            misaligned,
   output logic            halted
);

   pc_state_t       state;
   logic            accept;
   logic [XLEN-1:0] pc_nxt;
   logic            mis_nxt;
   logic            squash;

   assign fetch_valid = (state == PC_RUN);
   assign halted      = (state == PC_HALT);
   assign accept      = fetch_valid & fetch_ready;

   pc_next_sel #(
      .XLEN  (XLEN),
      .C_EXT (C_EXT)
   ) u_next_sel (
      .pc             (pc),
      .accept         (accept),
      .instr_len      (instr_len),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .trap_valid     (trap_valid),
      .trap_pc        (trap_pc),
      .pc_next        (pc_nxt),
      .misaligned     (mis_nxt),
      .squash         (squash)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= PC_BOOT;
         pc            <= RESET_VECTOR;
         pc_prev       <= '0;
         pc_prev_valid <= 1'b0;
         misaligned    <= 1'b0;
      end else begin
         pc_prev_valid <= 1'b0;
         misaligned    <= 1'b0;
         case (state)
            PC_BOOT: state <= PC_RUN;
            PC_RUN:  if (halt_req) state <= PC_HALT;
            PC_HALT: if (resume && !halt_req) state <= PC_RUN;
            default: state <= PC_BOOT;
         endcase
         // In HALT a trap/redirect is the debugger's pc write.
         if (state != PC_BOOT) begin
            pc         <= pc_nxt;
            misaligned <= mis_nxt;
         end
         if (accept && !squash) begin
            pc_prev       <= pc;
            pc_prev_valid <= 1'b1;
         end
      end
   end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the micore fetch front end; it replaces the single-register PC with a small controller. It holds the current fetch PC and offers it to instruction fetch over a valid/ready handshake. It advances by 4, or by 2 for compressed instructions, and accepts branch/jump redirects and trap vectors in a fixed priority. It also supports debug halt/resume and reports the last accepted PC to decode.

## Interface
- XLEN, 32, PC and address width (≥ 16)
- RESET_VECTOR, 'h0, PC value loaded on reset; must be 4-byte aligned
- C_EXT, 0, 1 enables 2-byte stepping and 2-byte redirect alignment

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- fetch_ready  in  1  fetch accepts the offered PC this cycle
- instr_len  in  1  length of the instruction at pc: 0 = 4 B, 1 = 2 B; ignored when C_EXT=0
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  XLEN  redirect target
- trap_valid  in  1  trap/exception entry
- trap_pc  in  XLEN  trap vector
- halt_req  in  1  debug halt request (level)
- resume  in  1  debug resume (pulse)
- fetch_valid  out  1  pc is a valid fetch request
- pc  out  XLEN  current fetch PC
- pc_prev  out  XLEN  PC accepted by fetch on the previous edge
- pc_prev_valid  out  1  one-cycle pulse: pc_prev was updated
- misaligned  out  1  one-cycle pulse: redirect target had illegal low bits
- halted  out  1  core is in HALT

## Operation
- States: BOOT, RUN, HALT. All outputs are registered or decoded from the state register.
  - fetch_valid = (state == RUN)
  - halted = (state == HALT)
- rst (overrides everything, including mid-operation) sets:
  - state = BOOT, pc = RESET_VECTOR, pc_prev = 0
  - pc_prev_valid = 0, misaligned = 0
- BOOT → RUN unconditionally on the next edge.
- accept = fetch_valid & fetch_ready.
- Next-pc priority, evaluated every cycle in RUN and HALT:
  1. trap_valid: pc ← trap_pc with bits [1:0] cleared.
  2. redirect_valid: pc ← redirect_pc with bit 0 cleared (C_EXT=1) or bits [1:0] cleared (C_EXT=0).
     - misaligned ← 1 if any cleared bit was set.
  3. accept: pc ← pc + step, where step = 2 if (C_EXT & instr_len), else 4.
     - The add is modulo 2^XLEN; it wraps silently.
  4. Otherwise pc holds.
- pc_prev / pc_prev_valid:
  - On accept with no trap/redirect in the same cycle: pc_prev ← pc and pc_prev_valid ← 1.
  - Accept coincident with trap/redirect counts as squashed: pc_prev_valid ← 0 and pc_prev holds.
  - Otherwise pc_prev_valid ← 0.
- Transitions:
  - RUN → HALT when halt_req. The next-pc update of that same cycle still applies.
  - HALT → RUN when resume & !halt_req; halt_req wins if both are asserted.
  - resume in RUN or BOOT is ignored.
- In HALT, fetch_valid = 0, so there is never an accept. Trap/redirect still load pc, which serves as the debug PC write; the state stays HALT.
- misaligned is cleared on every edge on which it is not set.

## Timing
- Reset released at edge E0: BOOT for one cycle; fetch_valid = 1 and pc = RESET_VECTOR after E1.
- Redirect/trap/accept sampled at edge N take effect on pc after N, which is one-cycle latency.
- fetch_valid stays high while fetch_ready is low, and pc is stable until accept or redirect. A redirect may change pc while it is un-accepted.
- halt_req sampled at edge N: halted = 1 and fetch_valid = 0 after N.
- resume sampled at edge N: fetch_valid = 1 after N.

## Structure
- Package pc_pkg:
  - pc_state_t enum {PC_BOOT, PC_RUN, PC_HALT}
  - PC_STEP_32 = 4 and PC_STEP_16 = 2 constants
- Sub-module pc_next_sel: combinational priority mux, adder, alignment clearing and misaligned detection.
- pc_gen holds the state register, pc, pc_prev and the pulse flags.

## Test plan
Parameters: XLEN=32, RESET_VECTOR=32'h0000_1000.
- Reset then fetch_ready = 1 for 3 cycles (C_EXT=0):
  - fetch_valid rises one cycle after BOOT.
  - pc goes 1000 → 1004 → 1008 → 100C.
  - pc_prev_valid pulses with pc_prev = 1000, 1004, 1008.
- Back-pressure: fetch_ready = 0 for 4 cycles at pc = 1004 → pc and fetch_valid hold, pc_prev_valid = 0.
- redirect_valid and trap_valid in the same cycle (redirect_pc = 2000, trap_pc = 3003, fetch_ready = 1):
  - pc = 3000, pc_prev_valid = 0, misaligned = 0.
- C_EXT=1, instr_len = 1 at pc = 1000 then instr_len = 0: pc goes 1002 → 1006. redirect_pc = 2001 gives pc = 2000 and a one-cycle misaligned pulse.
- Wrap: redirect to FFFF_FFFC, then accept → pc = 0000_0000.
- Halt, debug redirect, resume, then mid-run reset:
  - halt_req → halted = 1, fetch_valid = 0.
  - redirect_pc = 4000 while halted → pc = 4000, still halted.
  - resume with halt_req low → RUN, pc = 4000 offered.
  - rst asserted mid-run → pc = 1000, state BOOT, all pulses 0.
